// File: rtl/nlm_pkg.sv
// Shared widths and the per-stage payload of the NLM normalising divider.
// The divider turns the weighted pixel sum and weight sum produced by the
// systolic array into one rounded, saturated output pixel.
package nlm_pkg;

  localparam int DATA_WIDTH       = 12;
  localparam int WEIGHT_SUM_WIDTH = 14;
  localparam int PIX_SUM_WIDTH    = WEIGHT_SUM_WIDTH + DATA_WIDTH;
  localparam int LATENCY          = DATA_WIDTH + 2;

  // The remainder starts as the rounded numerator, one bit wider than the
  // pixel sum so that adding half the weight sum cannot wrap.
  localparam int REM_WIDTH        = PIX_SUM_WIDTH + 1;

  // Everything a sample needs while it walks down the division pipeline.
  typedef struct packed {
    logic                        valid;
    logic [REM_WIDTH-1:0]        rem;
    logic [WEIGHT_SUM_WIDTH-1:0] w;
    logic [DATA_WIDTH-1:0]       q;
    logic                        zero_w;
    logic                        ovf;
    logic [DATA_WIDTH-1:0]       center_pix;
  } stage_t;

  localparam stage_t STAGE_CLEAR = '0;

endpackage

// File: rtl/nlm_div_stage.sv
// One registered restoring-division step. Resolves quotient bit K by trying
// to subtract the divisor shifted left by K from the running remainder.
import nlm_pkg::*;

module nlm_div_stage #(
  parameter int K = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t upstream,
  output stage_t downstream
);

  // One guard bit above the remainder lets the trial difference go negative.
  localparam int TRIAL_WIDTH = REM_WIDTH + 1;

  logic        [TRIAL_WIDTH-1:0] divisor_sh;
  logic signed [TRIAL_WIDTH-1:0] trial;

  // Trial subtraction of the shifted divisor from the current remainder.
  always_comb begin
    divisor_sh = {{(TRIAL_WIDTH-WEIGHT_SUM_WIDTH){1'b0}}, upstream.w} << K;
    trial      = $signed({1'b0, upstream.rem}) - $signed(divisor_sh);
  end

  // Register the step: keep the difference only when it did not go negative.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      downstream <= STAGE_CLEAR;
    end else begin
      downstream <= upstream;
      if (trial >= 0) begin
        downstream.rem  <= trial[REM_WIDTH-1:0];
        downstream.q[K] <= 1'b1;
      end else begin
        downstream.q[K] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nlm_div.sv
// NLM normalising divider: pix_o = round(pix_sum_i / weight_sum_i), falling
// back to the centre pixel when no weight accumulated and clamping to full
// scale when the quotient does not fit. Fully pipelined, one sample per clock,
// fixed latency of DATA_WIDTH+2 cycles regardless of the data.
import nlm_pkg::*;

module nlm_div #(
  parameter int DATA_WIDTH       = nlm_pkg::DATA_WIDTH,
  parameter int WEIGHT_SUM_WIDTH = nlm_pkg::WEIGHT_SUM_WIDTH,
  parameter int PIX_SUM_WIDTH    = nlm_pkg::PIX_SUM_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  input  logic [PIX_SUM_WIDTH-1:0]    pix_sum_i,
  input  logic [WEIGHT_SUM_WIDTH-1:0] weight_sum_i,
  input  logic [DATA_WIDTH-1:0]       center_pix_i,
  output logic                        valid_o,
  output logic [DATA_WIDTH-1:0]       pix_o
);

  localparam int NUM_WIDTH = PIX_SUM_WIDTH + 1;

  // Largest representable pixel; used when the quotient would not fit.
  function automatic logic [DATA_WIDTH-1:0] saturate(
    input logic                  ovf,
    input logic [DATA_WIDTH-1:0] q
  );
    return ovf ? {DATA_WIDTH{1'b1}} : q;
  endfunction

  // Final pixel choice: a zero weight sum means no neighbour contributed,
  // so the original centre pixel is passed through untouched.
  function automatic logic [DATA_WIDTH-1:0] select_pix(input stage_t s);
    return s.zero_w ? s.center_pix : saturate(s.ovf, s.q);
  endfunction

  logic [NUM_WIDTH-1:0] num;
  logic [NUM_WIDTH-1:0] ovf_limit;
  stage_t               s_p0;
  stage_t               chain [0:DATA_WIDTH];

  // Round-half-up numerator and the first value whose quotient overflows.
  always_comb begin
    num       = {1'b0, pix_sum_i}
              + {{(NUM_WIDTH-WEIGHT_SUM_WIDTH){1'b0}}, weight_sum_i >> 1};
    ovf_limit = {{(NUM_WIDTH-WEIGHT_SUM_WIDTH-DATA_WIDTH){1'b0}},
                 weight_sum_i, {DATA_WIDTH{1'b0}}};
  end

  // ---- stage 0: numerator, special-case flags and centre pixel ----
  // Capture the sample and precompute the cases that bypass the quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p0 <= STAGE_CLEAR;
    end else begin
      s_p0.valid      <= valid_i;
      s_p0.rem        <= num;
      s_p0.w          <= weight_sum_i;
      s_p0.q          <= '0;
      s_p0.zero_w     <= (weight_sum_i == '0);
      s_p0.ovf        <= (num >= ovf_limit);
      s_p0.center_pix <= center_pix_i;
    end
  end

  assign chain[0] = s_p0;

  // ---- stages 1..DATA_WIDTH: one quotient bit each, MSB first ----
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_step
    nlm_div_stage #(
      .K(DATA_WIDTH - 1 - gi)
    ) u_step (
      .clk        (clk),
      .rst_n      (rst_n),
      .upstream   (chain[gi]),
      .downstream (chain[gi+1])
    );
  end

  // ---- output stage: select pixel, hold it across bubbles ----
  // Only valid samples update pix_o so the last good pixel stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      pix_o   <= '0;
    end else begin
      valid_o <= chain[DATA_WIDTH].valid;
      if (chain[DATA_WIDTH].valid) begin
        pix_o <= select_pix(chain[DATA_WIDTH]);
      end
    end
  end

endmodule

// File: doc/nlm_div.md
NLM_DIV -- requirements
Module: nlm_div

Interface
REQ-001 Parameter DATA_WIDTH, default 12: pixel width and quotient width.
REQ-002 Parameter WEIGHT_SUM_WIDTH, default 14: width of the accumulated weight sum (8-bit weights, 49 PEs).
REQ-003 Parameter PIX_SUM_WIDTH, default 26: width of the weighted pixel sum, equal to WEIGHT_SUM_WIDTH + DATA_WIDTH.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port valid_i, input, 1: pix_sum_i, weight_sum_i and center_pix_i are valid this cycle.
REQ-007 Port pix_sum_i, input, PIX_SUM_WIDTH: weighted pixel sum from the systolic array's final PE.
REQ-008 Port weight_sum_i, input, WEIGHT_SUM_WIDTH: weight sum from the systolic array's final PE.
REQ-009 Port center_pix_i, input, DATA_WIDTH: original center pixel, aligned with the sums; used as fallback.
REQ-010 Port valid_o, output, 1: pix_o is valid this cycle.
REQ-011 Port pix_o, output, DATA_WIDTH: denoised pixel, the rounded value of pix_sum_i / weight_sum_i.

Function
REQ-012 The block SHALL accept one sample per cycle, with no backpressure and no ready signal; throughput is 1 sample per clock.
REQ-013 The latency from a valid_i sample to its valid_o SHALL be exactly DATA_WIDTH+2 cycles (14 at default), fixed and independent of data.
REQ-014 Stage 0 SHALL register the numerator num = pix_sum_i + (weight_sum_i >> 1), computed at PIX_SUM_WIDTH+1 bits without truncation.
REQ-015 Stage 0 SHALL register the flags zero_w = (weight_sum_i == 0) and ovf = (num >= weight_sum_i << DATA_WIDTH), and SHALL register center_pix_i.
REQ-016 Stages 1..DATA_WIDTH SHALL each perform one restoring-division step, producing quotient bit k for k = DATA_WIDTH-1 down to 0 (MSB first).
- Each step computes trial = rem - (w << k).
- If trial >= 0: bit k = 1 and rem = trial. Otherwise: bit k = 0 and rem is unchanged.
- The initial rem is num.
REQ-017 Every stage SHALL carry valid, w, zero_w, ovf, center_pix and the partial quotient forward in lockstep.
REQ-018 The output stage SHALL register pix_o with priority zero_w, then ovf, then quotient:
- zero_w: pix_o = center_pix.
- ovf: pix_o = 2^DATA_WIDTH-1.
- otherwise: pix_o = quotient.
REQ-019 Pipeline stages holding invalid samples SHALL NOT update pix_o; pix_o holds its last valid value while valid_o = 0.
REQ-020 Bubbles (valid_i = 0) SHALL propagate as valid_o = 0 exactly DATA_WIDTH+2 cycles later; mixed valid/invalid patterns SHALL be preserved cycle for cycle.
REQ-021 A quotient of exactly 2^DATA_WIDTH-1 SHALL be output unsaturated, and ovf SHALL not be set for it.

Reset
REQ-022 While rst_n = 0, every pipeline register, valid_o and pix_o SHALL be 0, asynchronously.
REQ-023 Samples in flight when reset asserts SHALL be discarded; after rst_n releases, valid_o SHALL stay 0 until the first post-reset valid_i has traversed the full latency.

Structure
REQ-024 Package nlm_pkg SHALL hold DATA_WIDTH, WEIGHT_SUM_WIDTH, PIX_SUM_WIDTH, LATENCY = DATA_WIDTH+2, and the stage payload struct (valid, rem, w, q, zero_w, ovf, center_pix).
REQ-025 One sub-module, nlm_div_stage, SHALL implement a single registered division step, parameterised by bit index k; nlm_div SHALL instantiate it DATA_WIDTH times with a generate loop.

Verification
REQ-026 Nominal: pix_sum_i = 12495000, weight_sum_i = 12495, center_pix_i = 7, single valid pulse at cycle 0 -> valid_o = 1 at cycle 14 only, with pix_o = 1000.
REQ-027 Rounding: (pix_sum_i 7, weight_sum_i 2) -> pix_o = 4; (pix_sum_i 5, weight_sum_i 3) -> pix_o = 2; (pix_sum_i 4, weight_sum_i 3) -> pix_o = 1.
REQ-028 Zero weight: weight_sum_i = 0, pix_sum_i = 999, center_pix_i = 321 -> pix_o = 321 after 14 cycles.
REQ-029 Saturation: pix_sum_i = 12288, weight_sum_i = 3 -> pix_o = 4095; pix_sum_i = 12285, weight_sum_i = 3 -> pix_o = 4095 unsaturated, ovf = 0.
REQ-030 Streaming: 20 back-to-back samples with pix_sum_i = 49*n, weight_sum_i = 49 (n = 0..19), then a 1-cycle bubble, then 1 sample -> valid_o high for cycles 14-33, low at 34, high at 35; pix_o = 0..19 in order.
REQ-031 Reset mid-operation: rst_n low for 2 cycles at cycle 5 of a 10-sample stream -> valid_o = 0 and pix_o = 0 during reset, and no valid_o afterwards until a new valid_i is issued.
